dmem_ctrl: RTL and testbench

- Parametrised data-memory controller. Successor to the single-port word-only data RAM.
- Adds byte and halfword stores through byte enables, sign- and zero-extended loads, and a valid/ready request port with a registered one-cycle response.
- Adds misalignment faulting and a post-reset zero-clear sweep.
- Sits between the core's load/store stage and on-chip block RAM.

---
 rtl/dmem_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// Data-memory controller: byte/half/word loads and stores over a single-port word RAM,
// with a post-reset zero-clear sweep. Define DMEM_BOUNDS_CHECK_EN to fault addresses >= DEPTH*4.
module dmem_ctrl #(
    parameter  int DEPTH  = 64,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic        init_done,
    output logic        dbg_state
);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Handshake: a request is taken on a rising edge where req_valid && req_ready;
    // exactly one rsp_valid pulse follows in the next cycle, with no backpressure.

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              done_q, done_d;

    logic [31:0]       mem [DEPTH];
    logic [31:0]       rd_word_q;

    logic              rsp_valid_q;
    logic              rsp_fault_q;
    logic              load_ok_q;
    logic [1:0]        lane_q;
    logic [1:0]        size_q;
    logic              uns_q;

    logic              accept;
    logic [ADDR_W-1:0] idx;
    logic [1:0]        lane;
    logic              misalign;
    logic              oob;
    logic              fault;
    logic [3:0]        req_be;
    logic [31:0]       req_wrep;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_idx;
    logic [3:0]        wr_be;
    logic [31:0]       wr_data;

    assign accept = req_valid && (state_q == ST_RUN);
    assign idx    = req_addr[ADDR_W+1:2];
    assign lane   = req_addr[1:0];

    assign misalign = (req_size == 2'b11)
                   || (req_size == 2'b01 && lane[0])
                   || (req_size == 2'b10 && lane != 2'b00);

`ifdef DMEM_BOUNDS_CHECK_EN
    assign oob = |req_addr[31:ADDR_W+2];
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];
    assign oob = 1'b0;
`endif

    assign fault = misalign || oob;

    always_comb begin
        req_be   = 4'b0000;
        req_wrep = req_wdata;
        case (req_size)
            2'b00: begin
                req_be         = 4'b0000;
                req_be[lane]   = 1'b1;
                req_wrep       = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                req_be   = lane[1] ? 4'b1100 : 4'b0011;
                req_wrep = {2{req_wdata[15:0]}};
            end
            2'b10:   req_be = 4'b1111;
            default: req_be = 4'b0000;
        endcase
    end

    // The sweep owns the RAM port during INIT; requests cannot be accepted then.
    always_comb begin
        if (state_q == ST_INIT) begin
            wr_en   = 1'b1;
            wr_idx  = ptr_q;
            wr_be   = 4'b1111;
            wr_data = 32'h0;
        end else begin
            wr_en   = accept && req_we && !fault;
            wr_idx  = idx;
            wr_be   = req_be;
            wr_data = req_wrep;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        done_d  = done_q;
        if (state_q == ST_INIT) begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                state_d = ST_RUN;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
        if (accept && !req_we) rd_word_q <= mem[idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_fault_q <= 1'b0;
            load_ok_q   <= 1'b0;
            lane_q      <= 2'b00;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
        end else begin
            rsp_valid_q <= accept;
            if (accept) begin
                rsp_fault_q <= fault;
                load_ok_q   <= !req_we && !fault;
                lane_q      <= lane;
                size_q      <= req_size;
                uns_q       <= req_unsigned;
            end
        end
    end

    // Extraction runs on the registered word; lane/size regs only change on accept,
    // so rsp_rdata holds its value between pulses.
    logic [31:0] byte_shifted;
    logic [31:0] half_shifted;
    logic [31:0] load_val;

    assign byte_shifted = rd_word_q >> {lane_q, 3'b000};
    assign half_shifted = rd_word_q >> {lane_q[1], 4'b0000};

    always_comb begin
        case (size_q)
            2'b00:   load_val = {{24{!uns_q && byte_shifted[7]}}, byte_shifted[7:0]};
            2'b01:   load_val = {{16{!uns_q && half_shifted[15]}}, half_shifted[15:0]};
            default: load_val = rd_word_q;
        endcase
    end

    assign req_ready = (state_q == ST_RUN);
    assign init_done = done_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_fault = rsp_fault_q;
    assign rsp_rdata = load_ok_q ? load_val : 32'h0;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed scenarios plus random traffic checked against a
// byte-addressed memory model.
module tb_dmem_ctrl;
  localparam int DEPTH = 64;
  localparam int NBYTES = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic        init_done;
  logic        dbg_state;

  dmem_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_fault(rsp_fault), .init_done(init_done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  logic [7:0]  mref [NBYTES];
  logic [32:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < NBYTES; i++) mref[i] = 8'h00;
  endfunction

  // Returns {fault, rdata}; applies stores to the byte model.
  function automatic logic [32:0] model_access(input logic we, input logic [1:0] size,
                                               input logic uns, input logic [31:0] addr,
                                               input logic [31:0] wdata);
    int a;
    logic bad;
    logic [31:0] v;
    a = int'(addr % NBYTES);
    bad = (size == 2'b11) || (size == 2'b01 && (a % 2) != 0) || (size == 2'b10 && (a % 4) != 0);
`ifdef DMEM_BOUNDS_CHECK_EN
    if (addr >= NBYTES) bad = 1'b1;
`endif
    if (bad) return {1'b1, 32'h0};
    if (we) begin
      mref[a] = wdata[7:0];
      if (size != 2'b00) mref[a+1] = wdata[15:8];
      if (size == 2'b10) begin
        mref[a+2] = wdata[23:16];
        mref[a+3] = wdata[31:24];
      end
      return {1'b0, 32'h0};
    end
    if (size == 2'b00) begin
      v = {24'h0, mref[a]};
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (size == 2'b01) begin
      v = {16'h0, mref[a+1], mref[a]};
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = {mref[a+3], mref[a+2], mref[a+1], mref[a]};
    end
    return {1'b0, v};
  endfunction

  task automatic issue(input string tag, input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
    logic [32:0] e;
    req_valid = 1'b1;
    req_we = we;
    req_size = size;
    req_unsigned = uns;
    req_addr = addr;
    req_wdata = wdata;
    exp_q.push_back(model_access(we, size, uns, addr, wdata));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    e = exp_q.pop_front();
    check_eq({tag, ".valid"}, 32'(rsp_valid), 32'h1);
    check_eq({tag, ".fault"}, 32'(rsp_fault), 32'(e[32]));
    check_eq({tag, ".rdata"}, rsp_rdata, e[31:0]);
  endtask

  task automatic idle(input string tag);
    req_valid = 1'b0;
    req_we = 1'($urandom_range(0, 1));
    req_addr = $urandom();
    @(posedge clk);
    #1;
    check_eq({tag, ".novalid"}, 32'(rsp_valid), 32'h0);
  endtask

  task automatic release_and_init(input string tag);
    int lo;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    lo = 0;
    while (!req_ready && lo < 200) begin
      @(posedge clk);
      #1;
      lo++;
    end
    check_eq({tag, ".init_cycles"}, 32'(lo), 32'(DEPTH));
    check_eq({tag, ".init_done"}, 32'(init_done), 32'h1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    #2;
    check_eq("rst.ready", 32'(req_ready), 32'h0);
    check_eq("rst.valid", 32'(rsp_valid), 32'h0);
    check_eq("rst.rdata", rsp_rdata, 32'h0);
    check_eq("rst.fault", 32'(rsp_fault), 32'h0);
    check_eq("rst.done", 32'(init_done), 32'h0);
    #20;
    release_and_init("boot");

    issue("lw_0c", 1'b0, 2'b10, 1'b0, 32'h0C, 32'h0);
    issue("sw_10", 1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344);
    issue("sb_11", 1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AA);
    issue("lw_10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check_eq("lw_10.const", rsp_rdata, 32'h1122_AA44);
    issue("lb_11", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
    issue("lbu_11", 1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
    issue("sh_12", 1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_8001);
    issue("lh_12", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    issue("lhu_12", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
    issue("lw_10b", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check_eq("lw_10b.const", rsp_rdata, 32'h8001_AA44);
    issue("sw_20", 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFE_F00D);
    issue("lw_21", 1'b0, 2'b10, 1'b0, 32'h21, 32'h0);
    issue("sh_13", 1'b1, 2'b01, 1'b0, 32'h13, 32'hFFFF_FFFF);
    issue("ill_20", 1'b1, 2'b11, 1'b0, 32'h20, 32'h1234_5678);
    issue("lw_20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    idle("gap");
    issue("b2b_sw", 1'b1, 2'b10, 1'b0, 32'h04, 32'hDEAD_BEEF);
    issue("b2b_lw", 1'b0, 2'b10, 1'b0, 32'h04, 32'h0);
    check_eq("b2b_lw.const", rsp_rdata, 32'hDEAD_BEEF);
    issue("sw_00", 1'b1, 2'b10, 1'b0, 32'h00, 32'h0BAD_CAFE);
    issue("lw_100", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    idle("hold");
    check_eq("hold.rdata", rsp_rdata, exp_q.size() == 0 ? model_access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0) >> 0 : 33'h0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        idle("rnd_idle");
      end else begin
        a = 32'($urandom_range(0, NBYTES - 1));
        if ($urandom_range(0, 5) == 0) a = a | ($urandom() & 32'hFFFF_FF00);
        issue("rnd", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), a, $urandom());
      end
    end

    req_valid = 1'b1;
    req_we = 1'b0;
    req_size = 2'b10;
    req_addr = 32'h04;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("midrst.valid", 32'(rsp_valid), 32'h0);
    check_eq("midrst.ready", 32'(req_ready), 32'h0);
    check_eq("midrst.done", 32'(init_done), 32'h0);
    @(posedge clk);
    #1;
    check_eq("midrst.valid2", 32'(rsp_valid), 32'h0);
    release_and_init("reinit");
    issue("post_lw_04", 1'b0, 2'b10, 1'b0, 32'h04, 32'h0);
    check_eq("post_lw_04.const", rsp_rdata, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
